// File: rtl/trap_ctrl_if.sv
// Fetch redirect handshake between the trap sequencer and fetch.
// The trap sequencer drives the target; fetch acknowledges it.
interface trap_ctrl_if;
    logic        valid;
    logic [31:0] pc;
    logic        ready;

    modport master (
        output valid,
        output pc,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        output ready
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, mret and interrupts,
// writes the csr block and redirects fetch to the trap vector or mepc.
module trap_ctrl #(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [30:0] exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic        commit_valid,
    input  logic [31:0] commit_next_pc,
    input  logic        irq_ext_raw,
    input  logic        irq_sw_raw,
    input  logic        irq_timer_raw,
    input  logic        mie_meie,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    input  logic        csr_mstatus_mie,
    input  logic        csr_mstatus_mpie,
    input  logic [29:0] csr_mtvec_base,
    input  logic [1:0]  csr_mtvec_mode,
    input  logic [31:0] csr_mepc,
    output logic        take_trap,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mtval,
    output logic        trap_mcause_interrupt,
    output logic [30:0] trap_mcause_code,
    output logic        trap_mstatus_mie,
    output logic        trap_mstatus_mpie,
    output logic [1:0]  trap_mstatus_mpp,
    output logic        mret_wen,
    output logic        stall,
    trap_ctrl_if.master redirect
);

    typedef enum logic [1:0] {
        IDLE,
        TRAP_WR,
        MRET_WR,
        REDIRECT
    } state_t;

    state_t state, state_n;

    logic [IRQ_SYNC_STAGES-1:0] ext_q, sw_q, tmr_q;
    logic        ext_en, sw_en, tmr_en, irq_pend;
    logic [30:0] irq_code;
    logic        go_exc, go_mret, go_irq;

    logic [31:0] cap_mepc, cap_mtval, target;
    logic [30:0] cap_code;
    logic        cap_intr;
    logic [31:0] vec_base, vec_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q <= '0;
            sw_q  <= '0;
            tmr_q <= '0;
        end else begin
            ext_q[0] <= irq_ext_raw;
            sw_q[0]  <= irq_sw_raw;
            tmr_q[0] <= irq_timer_raw;
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) begin
                ext_q[i] <= ext_q[i-1];
                sw_q[i]  <= sw_q[i-1];
                tmr_q[i] <= tmr_q[i-1];
            end
        end
    end

    assign ext_en   = ext_q[IRQ_SYNC_STAGES-1] & mie_meie;
    assign sw_en    = sw_q[IRQ_SYNC_STAGES-1] & mie_msie;
    assign tmr_en   = tmr_q[IRQ_SYNC_STAGES-1] & mie_mtie;
    assign irq_pend = csr_mstatus_mie & (ext_en | sw_en | tmr_en);
    assign irq_code = ext_en ? 31'd11 : (sw_en ? 31'd3 : 31'd7);

    // Exception beats mret, mret beats a pending interrupt.
    assign go_exc  = (state == IDLE) & exc_valid;
    assign go_mret = (state == IDLE) & ~exc_valid & mret_valid;
    assign go_irq  = (state == IDLE) & ~exc_valid & ~mret_valid
                   & irq_pend & commit_valid;

    assign vec_base = {csr_mtvec_base, 2'b00};
    assign vec_off  = (csr_mtvec_mode == 2'd1 && cap_intr)
                    ? {cap_code[29:0], 2'b00} : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cap_mepc  <= '0;
            cap_mtval <= '0;
            cap_code  <= '0;
            cap_intr  <= 1'b0;
            target    <= '0;
        end else begin
            state <= state_n;
            if (go_exc) begin
                cap_mepc  <= exc_pc;
                cap_mtval <= exc_tval;
                cap_code  <= exc_code;
                cap_intr  <= 1'b0;
            end else if (go_irq) begin
                cap_mepc  <= commit_next_pc;
                cap_mtval <= '0;
                cap_code  <= irq_code;
                cap_intr  <= 1'b1;
            end
            if (state == TRAP_WR) target <= vec_base + vec_off;
            if (state == MRET_WR) target <= {csr_mepc[31:2], 2'b00};
        end
    end

    always_comb begin
        state_n           = state;
        take_trap         = 1'b0;
        mret_wen          = 1'b0;
        trap_mstatus_mie  = 1'b0;
        trap_mstatus_mpie = 1'b0;
        redirect.valid    = 1'b0;
        stall             = 1'b1;
        unique case (state)
            IDLE: begin
                stall = go_exc | go_mret | go_irq;
                if (go_exc | go_irq) state_n = TRAP_WR;
                else if (go_mret)    state_n = MRET_WR;
            end
            TRAP_WR: begin
                take_trap         = 1'b1;
                trap_mstatus_mpie = csr_mstatus_mie;
                state_n           = REDIRECT;
            end
            MRET_WR: begin
                mret_wen          = 1'b1;
                trap_mstatus_mie  = csr_mstatus_mpie;
                trap_mstatus_mpie = 1'b1;
                state_n           = REDIRECT;
            end
            REDIRECT: begin
                redirect.valid = 1'b1;
                if (redirect.ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign redirect.pc           = target;
    assign trap_mepc             = cap_mepc;
    assign trap_mtval            = cap_mtval;
    assign trap_mcause_code      = cap_code;
    assign trap_mcause_interrupt = cap_intr;
    assign trap_mstatus_mpp      = 2'b11;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, vectored irq, priority,
// mret, redirect backpressure and reset abort.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_valid = 0;
    logic [30:0] exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret_valid = 0;
    logic        commit_valid = 0;
    logic [31:0] commit_next_pc = '0;
    logic        irq_ext_raw = 0, irq_sw_raw = 0, irq_timer_raw = 0;
    logic        mie_meie = 0, mie_msie = 0, mie_mtie = 0;
    logic        csr_mstatus_mie = 0, csr_mstatus_mpie = 0;
    logic [29:0] csr_mtvec_base = '0;
    logic [1:0]  csr_mtvec_mode = '0;
    logic [31:0] csr_mepc = '0;
    logic        take_trap, trap_mcause_interrupt;
    logic [31:0] trap_mepc, trap_mtval;
    logic [30:0] trap_mcause_code;
    logic        trap_mstatus_mie, trap_mstatus_mpie;
    logic [1:0]  trap_mstatus_mpp;
    logic        mret_wen, stall;

    int errors = 0;
    int checks = 0;

    trap_ctrl_if rd ();

    trap_ctrl #(.IRQ_SYNC_STAGES(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .exc_valid             (exc_valid),
        .exc_code              (exc_code),
        .exc_pc                (exc_pc),
        .exc_tval              (exc_tval),
        .mret_valid            (mret_valid),
        .commit_valid          (commit_valid),
        .commit_next_pc        (commit_next_pc),
        .irq_ext_raw           (irq_ext_raw),
        .irq_sw_raw            (irq_sw_raw),
        .irq_timer_raw         (irq_timer_raw),
        .mie_meie              (mie_meie),
        .mie_msie              (mie_msie),
        .mie_mtie              (mie_mtie),
        .csr_mstatus_mie       (csr_mstatus_mie),
        .csr_mstatus_mpie      (csr_mstatus_mpie),
        .csr_mtvec_base        (csr_mtvec_base),
        .csr_mtvec_mode        (csr_mtvec_mode),
        .csr_mepc              (csr_mepc),
        .take_trap             (take_trap),
        .trap_mepc             (trap_mepc),
        .trap_mtval            (trap_mtval),
        .trap_mcause_interrupt (trap_mcause_interrupt),
        .trap_mcause_code      (trap_mcause_code),
        .trap_mstatus_mie      (trap_mstatus_mie),
        .trap_mstatus_mpie     (trap_mstatus_mpie),
        .trap_mstatus_mpp      (trap_mstatus_mpp),
        .mret_wen              (mret_wen),
        .stall                 (stall),
        .redirect              (rd.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd.ready = 1'b0;
        #2;
        check("rst_take", {31'd0, take_trap}, 0);
        check("rst_mret", {31'd0, mret_wen}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_rvalid", {31'd0, rd.valid}, 0);
        check("rst_rpc", rd.pc, 0);
        check("rst_mepc", trap_mepc, 0);
        check("rst_mpp", {30'd0, trap_mstatus_mpp}, 32'd3);
        #10 rst = 1'b1;
        tick();

        // Synchronous exception, mtvec direct mode.
        csr_mstatus_mie = 1;
        csr_mtvec_base = 30'h200;
        csr_mtvec_mode = 2'd0;
        rd.ready = 1'b1;
        exc_valid = 1;
        exc_code = 31'd2;
        exc_pc = 32'h100;
        exc_tval = 32'hDEAD;
        #1;
        check("exc_stall_idle", {31'd0, stall}, 1);
        tick();
        exc_valid = 0;
        exc_pc = 32'h0;
        #1;
        check("exc_take", {31'd0, take_trap}, 1);
        check("exc_mepc", trap_mepc, 32'h100);
        check("exc_code", {1'b0, trap_mcause_code}, 2);
        check("exc_intr", {31'd0, trap_mcause_interrupt}, 0);
        check("exc_mtval", trap_mtval, 32'hDEAD);
        check("exc_mpie", {31'd0, trap_mstatus_mpie}, 1);
        check("exc_mie", {31'd0, trap_mstatus_mie}, 0);
        check("exc_mretwen", {31'd0, mret_wen}, 0);
        tick();
        check("exc_rvalid", {31'd0, rd.valid}, 1);
        check("exc_rpc", rd.pc, 32'h800);
        check("exc_take_off", {31'd0, take_trap}, 0);
        tick();
        check("exc_idle_rv", {31'd0, rd.valid}, 0);
        check("exc_idle_stall", {31'd0, stall}, 0);

        // Vectored timer interrupt through the synchronizer.
        csr_mtvec_base = 30'h40;
        csr_mtvec_mode = 2'd1;
        mie_mtie = 1;
        commit_valid = 1;
        commit_next_pc = 32'h24;
        irq_timer_raw = 1;
        tick();
        check("tmr_sync1", {31'd0, stall}, 0);
        tick();
        check("tmr_sync2", {31'd0, stall}, 1);
        tick();
        irq_timer_raw = 0;
        rd.ready = 1'b0;
        #1;
        check("tmr_take", {31'd0, take_trap}, 1);
        check("tmr_code", {1'b0, trap_mcause_code}, 7);
        check("tmr_intr", {31'd0, trap_mcause_interrupt}, 1);
        check("tmr_mepc", trap_mepc, 32'h24);
        check("tmr_mtval", trap_mtval, 0);
        // Backpressure: five cycles with fetch not ready.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rvalid", {31'd0, rd.valid}, 1);
            check("bp_rpc", rd.pc, 32'h11C);
            check("bp_stall", {31'd0, stall}, 1);
        end
        rd.ready = 1'b1;
        tick();
        check("bp_exit", {31'd0, rd.valid}, 0);
        check("bp_exit_stall", {31'd0, stall}, 0);
        mie_mtie = 0;

        // Exception and external irq pending together.
        csr_mtvec_base = 30'h200;
        csr_mtvec_mode = 2'd0;
        mie_meie = 1;
        commit_next_pc = 32'h5004;
        irq_ext_raw = 1;
        tick();
        tick();
        exc_valid = 1;
        exc_code = 31'd5;
        exc_pc = 32'h500;
        exc_tval = 32'h0;
        tick();
        exc_valid = 0;
        #1;
        check("sim_take", {31'd0, take_trap}, 1);
        check("sim_intr", {31'd0, trap_mcause_interrupt}, 0);
        check("sim_code", {1'b0, trap_mcause_code}, 5);
        tick();
        check("sim_rpc", rd.pc, 32'h800);
        tick();
        check("sim_idle_stall", {31'd0, stall}, 1);
        tick();
        irq_ext_raw = 0;
        #1;
        check("ext_take", {31'd0, take_trap}, 1);
        check("ext_intr", {31'd0, trap_mcause_interrupt}, 1);
        check("ext_code", {1'b0, trap_mcause_code}, 11);
        check("ext_mepc", trap_mepc, 32'h5004);
        tick();
        check("ext_rpc", rd.pc, 32'h800);
        tick();
        check("ext_done", {31'd0, stall}, 0);
        mie_meie = 0;
        commit_valid = 0;

        // Software irq with vector address wrapping past 2^32.
        csr_mtvec_base = 30'h3FFF_FFFF;
        csr_mtvec_mode = 2'd1;
        mie_msie = 1;
        commit_valid = 1;
        irq_sw_raw = 1;
        tick();
        tick();
        tick();
        irq_sw_raw = 0;
        #1;
        check("sw_code", {1'b0, trap_mcause_code}, 3);
        tick();
        check("sw_wrap_rpc", rd.pc, 32'h8);
        tick();
        mie_msie = 0;
        commit_valid = 0;
        tick();
        tick();

        // mret restores mie from mpie and aligns mepc.
        csr_mstatus_mie = 0;
        csr_mstatus_mpie = 1;
        csr_mepc = 32'h303;
        mret_valid = 1;
        #1;
        check("mret_stall_idle", {31'd0, stall}, 1);
        tick();
        mret_valid = 0;
        #1;
        check("mret_wen", {31'd0, mret_wen}, 1);
        check("mret_take", {31'd0, take_trap}, 0);
        check("mret_mie", {31'd0, trap_mstatus_mie}, 1);
        check("mret_mpie", {31'd0, trap_mstatus_mpie}, 1);
        tick();
        check("mret_rpc", rd.pc, 32'h300);
        check("mret_wen_off", {31'd0, mret_wen}, 0);
        tick();
        check("mret_idle", {31'd0, stall}, 0);

        // Reset while waiting in REDIRECT aborts the sequence.
        rd.ready = 1'b0;
        exc_valid = 1;
        exc_pc = 32'h700;
        tick();
        exc_valid = 0;
        tick();
        check("ar_rvalid", {31'd0, rd.valid}, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_rvalid0", {31'd0, rd.valid}, 0);
        check("ar_stall0", {31'd0, stall}, 0);
        check("ar_rpc0", rd.pc, 0);
        check("ar_mepc0", trap_mepc, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ar_post_rv", {31'd0, rd.valid}, 0);
        check("ar_post_stall", {31'd0, stall}, 0);
        check("ar_post_take", {31'd0, take_trap}, 0);
        tick();
        check("ar_post_rv2", {31'd0, rd.valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
